// File: rtl/posit_decoder_pipe_if.sv
// Beat interface for posit_decoder_pipe.
//   Input side : in_valid_i / in_ready_o handshake, operand_i (LANES packed posit words)
//   Output side: out_valid_o / out_ready_i handshake, per-lane sign_o, rg_exp_o,
//                mant_norm_o, is_zero_o, is_nar_o
// slave  = decoder view, master = producer/consumer view.
interface posit_decoder_pipe_if #(
  parameter int unsigned n     = 16,
  parameter int unsigned es    = 1,
  parameter int unsigned LANES = 4
);
  localparam int unsigned ND         = $clog2(n - 1);
  localparam int unsigned EXP_WIDTH  = ND + es;
  localparam int unsigned MANT_WIDTH = n - es - 3;
  localparam int unsigned RG_W       = EXP_WIDTH + 1;
  localparam int unsigned MN_W       = MANT_WIDTH + 1;

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [LANES*n-1:0]       operand_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [LANES-1:0]         sign_o;
  logic [LANES*RG_W-1:0]    rg_exp_o;
  logic [LANES*MN_W-1:0]    mant_norm_o;
  logic [LANES-1:0]         is_zero_o;
  logic [LANES-1:0]         is_nar_o;

  modport slave (
    input  in_valid_i, operand_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_o, rg_exp_o, mant_norm_o, is_zero_o, is_nar_o
  );

  modport master (
    output in_valid_i, operand_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_o, rg_exp_o, mant_norm_o, is_zero_o, is_nar_o
  );
endinterface

// File: rtl/posit_decoder_pipe.sv
// Two-stage elastic multi-lane posit decoder.
//   clk_i : clock
//   rst_i : synchronous active-high reset (discards in-flight beats)
//   bus   : posit_decoder_pipe_if.slave -- input beat handshake + operands,
//           output beat handshake + per-lane sign / regime-exponent / mantissa / flags
// S1 captures sign, magnitude, regime run length and special flags.
// S2 strips the regime, extracts exponent and fraction and applies special-word overrides.
module posit_decoder_pipe #(
  parameter int unsigned n     = 16,
  parameter int unsigned es    = 1,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  posit_decoder_pipe_if.slave    bus
);
  localparam int unsigned ND         = $clog2(n - 1);
  localparam int unsigned EXP_WIDTH  = ND + es;
  localparam int unsigned MANT_WIDTH = n - es - 3;
  localparam int unsigned RG_W       = EXP_WIDTH + 1;
  localparam int unsigned MN_W       = MANT_WIDTH + 1;
  localparam int unsigned MAG_W      = n - 1;
  localparam int unsigned RUN_W      = $clog2(n);
  localparam int unsigned DEC_W      = RG_W + MN_W;

  // Length of the leading run of identical bits starting at the MSB.
  function automatic logic [RUN_W-1:0] lead_run(input logic [MAG_W-1:0] m);
    logic [RUN_W-1:0] cnt;
    logic             more;
    cnt  = '0;
    more = 1'b1;
    for (int b = int'(MAG_W) - 1; b >= 0; b--) begin
      if (more && (m[b] == m[MAG_W-1])) cnt = cnt + RUN_W'(1);
      else                               more = 1'b0;
    end
    return cnt;
  endfunction

  // Regime removal: returns {rg_exp, implicit, fraction} for a normal word.
  function automatic logic [DEC_W-1:0] decode(input logic [MAG_W-1:0] mag,
                                              input logic [RUN_W-1:0] run);
    logic [RUN_W:0]    shamt;
    logic [MAG_W-1:0]  sh;
    logic [RG_W-1:0]   k;
    logic [RG_W-1:0]   rg;
    shamt = {1'b0, run} + (RUN_W+1)'(1);
    if (shamt > (RUN_W+1)'(MAG_W)) shamt = (RUN_W+1)'(MAG_W);
    sh = mag << shamt;
    // Run of ones -> k = run-1, run of zeros -> k = -run (modular arithmetic).
    k  = mag[MAG_W-1] ? (RG_W'(run) - RG_W'(1)) : (RG_W'(0) - RG_W'(run));
    // Low es bits of k<<es are zero, so OR inserts the exponent field.
    rg = (k << es) | RG_W'(sh >> (MAG_W - es));
    // Fraction sits below the exponent; the two LSBs of sh are never used.
    return {rg, 1'b1, MANT_WIDTH'(sh >> 2)};
  endfunction

  logic                     r_s1_valid;
  logic [LANES-1:0]         r_s1_sign;
  logic [LANES*MAG_W-1:0]   r_s1_mag;
  logic [LANES*RUN_W-1:0]   r_s1_run;
  logic [LANES-1:0]         r_s1_zero;
  logic [LANES-1:0]         r_s1_nar;

  logic                     r_s2_valid;
  logic [LANES-1:0]         r_sign;
  logic [LANES*RG_W-1:0]    r_rg;
  logic [LANES*MN_W-1:0]    r_mant;
  logic [LANES-1:0]         r_zero;
  logic [LANES-1:0]         r_nar;

  logic                     w_s2_load;
  logic                     w_in_ready;
  logic                     w_in_fire;
  logic [LANES-1:0]         w_sign;
  logic [LANES*MAG_W-1:0]   w_mag;
  logic [LANES*RUN_W-1:0]   w_run;
  logic [LANES-1:0]         w_zero;
  logic [LANES-1:0]         w_nar;
  logic [LANES*DEC_W-1:0]   w_dec;

  // Flow control: S2 refills whenever it drains; S1 accepts when it drains into S2.
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready_i);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_in_fire  = bus.in_valid_i && w_in_ready;

  // S1 combinational: sign, magnitude, regime run, special flags.
  always_comb begin
    w_sign = '0;
    w_mag  = '0;
    w_run  = '0;
    w_zero = '0;
    w_nar  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_sign[l] = bus.operand_i[l*n + n - 1];
      w_zero[l] = (bus.operand_i[l*n +: n] == '0);
      w_nar[l]  = (bus.operand_i[l*n +: n] == {1'b1, {(n-1){1'b0}}});
      w_mag[l*MAG_W +: MAG_W] = bus.operand_i[l*n + n - 1]
                              ? (MAG_W'(0) - bus.operand_i[l*n +: MAG_W])
                              : bus.operand_i[l*n +: MAG_W];
      w_run[l*RUN_W +: RUN_W] = lead_run(w_mag[l*MAG_W +: MAG_W]);
    end
  end

  // S2 combinational: regime removal from the S1 registers.
  always_comb begin
    w_dec = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_dec[l*DEC_W +: DEC_W] = decode(r_s1_mag[l*MAG_W +: MAG_W], r_s1_run[l*RUN_W +: RUN_W]);
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= '0;
      r_s1_mag   <= '0;
      r_s1_run   <= '0;
      r_s1_zero  <= '0;
      r_s1_nar   <= '0;
      r_s2_valid <= 1'b0;
      r_sign     <= '0;
      r_rg       <= '0;
      r_mant     <= '0;
      r_zero     <= '0;
      r_nar      <= '0;
    end else begin
      r_s1_valid <= w_in_fire || (r_s1_valid && !w_s2_load);
      r_s2_valid <= w_s2_load || (r_s2_valid && !bus.out_ready_i);
      if (w_in_fire) begin
        r_s1_sign <= w_sign;
        r_s1_mag  <= w_mag;
        r_s1_run  <= w_run;
        r_s1_zero <= w_zero;
        r_s1_nar  <= w_nar;
      end
      if (w_s2_load) begin
        for (int l = 0; l < int'(LANES); l++) begin
          r_zero[l] <= r_s1_zero[l];
          r_nar[l]  <= r_s1_nar[l];
          if (r_s1_zero[l] || r_s1_nar[l]) begin
            // Special words: sign reflects NaR only, payload cleared.
            r_sign[l]               <= r_s1_nar[l];
            r_rg[l*RG_W +: RG_W]    <= '0;
            r_mant[l*MN_W +: MN_W]  <= '0;
          end else begin
            r_sign[l]               <= r_s1_sign[l];
            r_rg[l*RG_W +: RG_W]    <= w_dec[l*DEC_W + MN_W +: RG_W];
            r_mant[l*MN_W +: MN_W]  <= w_dec[l*DEC_W +: MN_W];
          end
        end
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_s2_valid;
  assign bus.sign_o      = r_sign;
  assign bus.rg_exp_o    = r_rg;
  assign bus.mant_norm_o = r_mant;
  assign bus.is_zero_o   = r_zero;
  assign bus.is_nar_o    = r_nar;
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Self-checking bench for posit_decoder_pipe (n=16, es=1, LANES=4).
module tb_posit_decoder_pipe;
  localparam int unsigned N     = 16;
  localparam int unsigned ES    = 1;
  localparam int unsigned L     = 4;
  localparam int unsigned RG_W  = 6;
  localparam int unsigned MN_W  = 13;
  localparam int unsigned MW    = 12;
  localparam int unsigned LW    = 1 + RG_W + MN_W + 2;
  localparam int unsigned OBS_W = L * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_decoder_pipe_if #(.n(N), .es(ES), .LANES(L)) bus ();

  posit_decoder_pipe #(.n(N), .es(ES), .LANES(L)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp;
  int n_fail;
  logic [L*N-1:0]   exp_q[$];
  logic             s_in_fire, s_out_fire, s_in_ready, s_out_valid;
  logic [OBS_W-1:0] s_obs;

  // Reference decode of one posit word: {sign, rg_exp, mant, is_zero, is_nar}.
  function automatic logic [LW-1:0] ref_lane(input logic [N-1:0] w);
    int unsigned v, run, b, rest, e, fa, fr;
    int k, rem;
    logic s;
    logic [RG_W-1:0] rg;
    if (w == 16'h0000) return {1'b0, 6'd0, 13'd0, 1'b1, 1'b0};
    if (w == 16'h8000) return {1'b1, 6'd0, 13'd0, 1'b0, 1'b1};
    s = w[N-1];
    v = s ? ((32'h10000 - 32'(w)) & 32'hFFFF) : 32'(w);
    b = (v >> (N-2)) & 1;
    run = 0;
    for (int i = int'(N) - 2; i >= 0; i--) begin
      if (((v >> i) & 1) == b) run++;
      else break;
    end
    k = (b == 1) ? int'(run) - 1 : -int'(run);
    rem = int'(N) - 2 - int'(run);
    if (rem < 0) rem = 0;
    rest = v & ((32'd1 << rem) - 1);
    if (rem >= int'(ES)) e = rest >> (rem - int'(ES));
    else                 e = rest << (int'(ES) - rem);
    fa = (rem >= int'(ES)) ? 32'(rem - int'(ES)) : 0;
    fr = (rest & ((32'd1 << fa) - 1)) << (MW - fa);
    rg = RG_W'(k * (1 << ES) + int'(e));
    return {s, rg, 1'b1, MW'(fr), 2'b00};
  endfunction

  function automatic logic [OBS_W-1:0] ref_beat(input logic [L*N-1:0] ops);
    logic [L-1:0]      sg, z, nr;
    logic [L*RG_W-1:0] rg;
    logic [L*MN_W-1:0] mn;
    logic [LW-1:0]     d;
    for (int i = 0; i < int'(L); i++) begin
      d = ref_lane(ops[i*N +: N]);
      sg[i] = d[LW-1];
      rg[i*RG_W +: RG_W] = d[LW-2 -: RG_W];
      mn[i*MN_W +: MN_W] = d[MN_W+1:2];
      z[i]  = d[1];
      nr[i] = d[0];
    end
    return {sg, rg, mn, z, nr};
  endfunction

  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0001;
      4:       return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [L*N-1:0] rand_beat();
    return {rand_word(), rand_word(), rand_word(), rand_word()};
  endfunction

  // One clock: drive at negedge, observe 1 time unit later (before next posedge).
  task automatic step(input logic r, input logic v, input logic [L*N-1:0] op, input logic rdy);
    @(negedge clk);
    rst = r;
    bus.in_valid_i  = v;
    bus.operand_i   = op;
    bus.out_ready_i = rdy;
    #1;
    s_in_ready  = bus.in_ready_o;
    s_out_valid = bus.out_valid_o;
    s_in_fire   = v && bus.in_ready_o;
    s_out_fire  = bus.out_valid_o && rdy;
    s_obs = {bus.sign_o, bus.rg_exp_o, bus.mant_norm_o, bus.is_zero_o, bus.is_nar_o};
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, rand_beat(), 1'b1);
    n_cmp++;
    if (s_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid);
    end
    n_cmp++;
    if (s_obs !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", s_obs);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_cmp++;
    if (s_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", s_in_ready);
    end
    n_cmp++;
    if (s_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_phantom: got %b expected 0", s_out_valid);
    end
  endtask

  task automatic test_directed();
    logic [L*N-1:0]    ops [2];
    logic [L-1:0]      e_sg [2], e_z [2], e_nr [2];
    logic [L*RG_W-1:0] e_rg [2];
    logic [L*MN_W-1:0] e_mn [2];
    int lat;
    logic [OBS_W-1:0] got;
    ops[0] = {16'hC000, 16'h4800, 16'h5000, 16'h4000};
    e_sg[0] = 4'b1000; e_z[0] = 4'b0000; e_nr[0] = 4'b0000;
    e_rg[0] = {6'd0, 6'd0, 6'd1, 6'd0};
    e_mn[0] = {13'h1000, 13'h1800, 13'h1000, 13'h1000};
    ops[1] = {16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
    e_sg[1] = 4'b1000; e_z[1] = 4'b0100; e_nr[1] = 4'b1000;
    e_rg[1] = {6'd0, 6'd0, 6'h24, 6'd28};
    e_mn[1] = {13'h0000, 13'h0000, 13'h1000, 13'h1000};
    for (int t = 0; t < 2; t++) begin
      step(1'b0, 1'b1, ops[t], 1'b1);
      n_cmp++;
      if (s_in_fire !== 1'b1) begin
        n_fail++; $display("FAIL directed_accept[%0d]: got %b expected 1", t, s_in_fire);
      end
      lat = 0;
      got = '0;
      for (int c = 1; c <= 6; c++) begin
        step(1'b0, 1'b0, '0, 1'b1);
        if (s_out_valid && lat == 0) begin
          lat = c;
          got = s_obs;
        end
      end
      n_cmp++;
      if (lat !== 2) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 2", t, lat);
      end
      n_cmp++;
      if (got[OBS_W-1 -: L] !== e_sg[t]) begin
        n_fail++; $display("FAIL directed_sign[%0d]: got %b expected %b", t, got[OBS_W-1 -: L], e_sg[t]);
      end
      n_cmp++;
      if (got[OBS_W-L-1 -: L*RG_W] !== e_rg[t]) begin
        n_fail++; $display("FAIL directed_rg_exp[%0d]: got %h expected %h", t, got[OBS_W-L-1 -: L*RG_W], e_rg[t]);
      end
      n_cmp++;
      if (got[2*L +: L*MN_W] !== e_mn[t]) begin
        n_fail++; $display("FAIL directed_mant[%0d]: got %h expected %h", t, got[2*L +: L*MN_W], e_mn[t]);
      end
      n_cmp++;
      if (got[2*L-1:0] !== {e_z[t], e_nr[t]}) begin
        n_fail++; $display("FAIL directed_flags[%0d]: got %b expected %b", t, got[2*L-1:0], {e_z[t], e_nr[t]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [L*N-1:0]   cur, h;
    logic [OBS_W-1:0] e;
    int sent, got, first, last;
    exp_q.delete();
    sent = 0; got = 0; first = -1; last = -1;
    cur = rand_beat();
    for (int c = 0; c < 70; c++) begin
      step(1'b0, sent < 64, cur, 1'b1);
      if (sent < 64) begin
        n_cmp++;
        if (s_in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", c, s_in_ready);
        end
      end
      if (s_out_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_beat cyc %0d: got %h expected none", c, s_obs);
        end else begin
          h = exp_q.pop_front();
          e = ref_beat(h);
          if (s_obs !== e) begin
            n_fail++; $display("FAIL b2b_data beat %0d: got %h expected %h (in %h)", got, s_obs, e, h);
          end
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (s_in_fire) begin
        exp_q.push_back(cur);
        sent++;
        cur = rand_beat();
      end
    end
    n_cmp++;
    if (got !== 64) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 64", got);
    end
    n_cmp++;
    if (last - first !== 63) begin
      n_fail++; $display("FAIL b2b_throughput: got span %0d expected 63", last - first);
    end
    n_cmp++;
    if (first !== 2) begin
      n_fail++; $display("FAIL b2b_first_latency: got %0d expected 2", first);
    end
  endtask

  task automatic test_stall();
    logic [L*N-1:0]   beats [4];
    logic [L*N-1:0]   h;
    int idx, got;
    exp_q.delete();
    for (int i = 0; i < 3; i++) beats[i] = rand_beat();
    beats[3] = '0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, idx < 3, beats[idx], 1'b0);
      if (s_out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || s_obs !== ref_beat(exp_q[0])) begin
          n_fail++; $display("FAIL stall_hold cyc %0d: got %h expected %h", c, s_obs, ref_beat(beats[0]));
        end
      end
      if (s_in_fire) begin
        exp_q.push_back(beats[idx]);
        idx++;
      end
    end
    n_cmp++;
    if (idx !== 2) begin
      n_fail++; $display("FAIL stall_accepted: got %0d expected 2", idx);
    end
    n_cmp++;
    if (s_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready: got %b expected 0", s_in_ready);
    end
    got = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, idx < 3, beats[idx], 1'b1);
      if (s_out_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra_beat: got %h expected none", s_obs);
        end else begin
          h = exp_q.pop_front();
          if (s_obs !== ref_beat(h) || h !== beats[got]) begin
            n_fail++; $display("FAIL stall_release beat %0d: got %h expected %h", got, s_obs, ref_beat(beats[got]));
          end
        end
        got++;
      end
      if (s_in_fire) begin
        exp_q.push_back(beats[idx]);
        idx++;
      end
    end
    n_cmp++;
    if (got !== 3 || idx !== 3) begin
      n_fail++; $display("FAIL stall_delivered: got %0d out / %0d in expected 3 / 3", got, idx);
    end
  endtask

  task automatic test_random_flow();
    logic [L*N-1:0] cur, h;
    logic pending, v, rdy;
    int sent, got;
    exp_q.delete();
    sent = 0; got = 0; pending = 1'b0;
    cur = rand_beat();
    for (int c = 0; c < 10000 && got < 1000; c++) begin
      v = pending || (sent < 1000 && $urandom_range(0, 1) == 1);
      if (v) pending = 1'b1;
      rdy = ($urandom_range(0, 1) == 1);
      step(1'b0, v, cur, rdy);
      if (s_out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL flow_spurious cyc %0d: got %h expected none", c, s_obs);
        end else if (s_obs !== ref_beat(exp_q[0])) begin
          n_fail++; $display("FAIL flow_data beat %0d: got %h expected %h", got, s_obs, ref_beat(exp_q[0]));
        end
        if (s_out_fire && exp_q.size() != 0) begin
          h = exp_q.pop_front();
          got++;
        end
      end
      if (s_in_fire) begin
        exp_q.push_back(cur);
        sent++;
        pending = 1'b0;
        cur = rand_beat();
      end
    end
    n_cmp++;
    if (sent !== 1000 || got !== 1000) begin
      n_fail++; $display("FAIL flow_count: got %0d in / %0d out expected 1000 / 1000", sent, got);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL flow_lost: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [L*N-1:0] f;
    int outs, lat;
    exp_q.delete();
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, rand_beat(), 1'b0);
    n_cmp++;
    if (s_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_full: got in_ready %b expected 0", s_in_ready);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    n_cmp++;
    if (s_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", s_out_valid);
    end
    n_cmp++;
    if (s_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", s_in_ready);
    end
    f = rand_beat();
    step(1'b0, 1'b1, f, 1'b1);
    outs = 0; lat = 0;
    for (int c = 1; c <= 6; c++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (s_out_valid) begin
        outs++;
        if (lat == 0) begin
          lat = c;
          n_cmp++;
          if (s_obs !== ref_beat(f)) begin
            n_fail++; $display("FAIL midrst_fresh_data: got %h expected %h", s_obs, ref_beat(f));
          end
        end
      end
    end
    n_cmp++;
    if (outs !== 1 || lat !== 2) begin
      n_fail++; $display("FAIL midrst_fresh_beat: got %0d outs latency %0d expected 1 outs latency 2", outs, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.operand_i   = '0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random_flow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
